// File: rtl/alu_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_command_sequencer
//  Purpose  : Sequential front-end for the combinational 16-bit calculator.
//             Accepts one command at a time, holds it on the calculator for
//             SETTLE_CYCLES clocks, then captures result and opcode-masked
//             error into an in-order response FIFO.
//  Ports    : clk, rst (async, active-high)
//             cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b   command port
//             alu_input1/alu_input2/alu_opcode             to calculator
//             alu_result/alu_error                         from calculator
//             rsp_valid/rsp_ready/rsp_result/rsp_error/rsp_opcode  response
//             busy (command in flight), err_count (saturating error count)
//  Revision : 1.0  initial release
// ============================================================================
module alu_command_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RSP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_input1,
    output logic [15:0] alu_input2,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [3:0]  rsp_opcode,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int             PTR_W    = $clog2(RSP_DEPTH);
    localparam logic [3:0]     SETTLE_C = 4'(SETTLE_CYCLES);
    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(RSP_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [15:0]      in1_q, in1_d;
    logic [15:0]      in2_q, in2_d;
    logic [3:0]       op_q, op_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             push;
    logic             pop;
    logic [1:0]       masked_err;

    // Response storage: only written on push, read through the head pointer,
    // so it carries no reset; outputs are gated by rsp_valid instead.
    logic [31:0]      res_mem [RSP_DEPTH];
    logic [1:0]       err_mem [RSP_DEPTH];
    logic [3:0]       op_mem  [RSP_DEPTH];

    assign cmd_ready  = (state_q == ST_IDLE) && (count_q < DEPTH_C);
    assign busy       = (state_q == ST_WAIT);
    assign rsp_valid  = (count_q != '0);
    assign rsp_result = rsp_valid ? res_mem[rd_ptr_q] : 32'd0;
    assign rsp_error  = rsp_valid ? err_mem[rd_ptr_q] : 2'd0;
    assign rsp_opcode = rsp_valid ? op_mem[rd_ptr_q]  : 4'd0;
    assign alu_input1 = in1_q;
    assign alu_input2 = in2_q;
    assign alu_opcode = op_q;
    assign err_count  = err_count_q;

    // Only divide/mod can legitimately report divide-by-zero and only
    // add/sub can overflow; anything else the calculator flags is noise.
    assign masked_err = {alu_error[1] & ((op_q == 4'd4) || (op_q == 4'd5)),
                         alu_error[0] & ((op_q == 4'd1) || (op_q == 4'd2))};

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        op_d        = op_q;
        push        = 1'b0;
        pop         = rsp_valid && rsp_ready;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = ST_WAIT;
                    settle_d = SETTLE_C;
                    in1_d    = cmd_a;
                    in2_d    = cmd_b;
                    op_d     = cmd_opcode;
                end
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                // Counter at 1 means this edge takes it to 0: capture now.
                if (settle_q == 4'd1) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                    op_d    = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        err_count_d = err_count_q;
        if (push && (masked_err != 2'b00) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= 4'd0;
            in1_q       <= 16'd0;
            in2_q       <= 16'd0;
            op_q        <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            op_q        <= op_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr_q] <= alu_result;
            err_mem[wr_ptr_q] <= masked_err;
            op_mem[wr_ptr_q]  <= op_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_command_sequencer
//  Purpose  : Self-checking bench for alu_command_sequencer. A behavioural
//             calculator drives the alu_result/alu_error pins; a response
//             queue model is compared against the DUT every cycle, and
//             directed scenarios add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_command_sequencer;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = 4'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [3:0]  rsp_opcode;
    logic        busy;
    logic [7:0]  err_count;
    logic [1:0]  force_err = 2'b00;   // extra error bits the calculator raises

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc = 0;

    always #5 clk = ~clk;

    alu_command_sequencer #(.SETTLE_CYCLES(SETTLE), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_opcode(rsp_opcode),
        .busy(busy), .err_count(err_count)
    );

    // Behavioural calculator: {error, result}
    function automatic logic [33:0] calc(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [1:0] frc);
        logic [31:0] r;
        logic [1:0]  e;
        r = 32'd0;
        e = 2'b00;
        case (op)
            4'd1: begin r = 32'(a) + 32'(b); e[0] = (r > 32'h0000FFFF); end
            4'd2: begin r = 32'(a) - 32'(b); e[0] = (a < b); end
            4'd3: r = 32'(a) * 32'(b);
            4'd4: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a / b);
            4'd5: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a % b);
            default: ;
        endcase
        return {e | frc, r};
    endfunction

    assign {alu_error, alu_result} = calc(alu_opcode, alu_input1, alu_input2, force_err);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  err;
        logic [3:0]  op;
    } rsp_t;

    rsp_t        mq[$];
    bit          m_busy;
    int          m_cap;
    logic [15:0] m_in1, m_in2;
    logic [3:0]  m_op;
    int          m_errcnt;
    bit          m_rdy;
    logic [31:0] m_r;
    logic [1:0]  m_e;
    rsp_t        m_rr;

    task automatic m_clear();
        mq.delete();
        m_busy = 0; m_in1 = 16'd0; m_in2 = 16'd0; m_op = 4'd0; m_errcnt = 0;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_clear();
            end else begin
                m_rdy = !m_busy && (mq.size() < DEPTH);
                if (mq.size() > 0 && rsp_ready) void'(mq.pop_front());
                if (m_busy && cyc == m_cap) begin
                    {m_e, m_r} = calc(m_op, m_in1, m_in2, force_err);
                    m_rr.res = m_r;
                    m_rr.err = {m_e[1] && (m_op == 4'd4 || m_op == 4'd5),
                                m_e[0] && (m_op == 4'd1 || m_op == 4'd2)};
                    m_rr.op  = m_op;
                    mq.push_back(m_rr);
                    if (m_rr.err != 2'b00 && m_errcnt < 255) m_errcnt++;
                    m_busy = 0;
                    m_op   = 4'd0;
                end else if (m_rdy && cmd_valid) begin
                    m_busy = 1;
                    m_cap  = cyc + SETTLE;
                    m_in1  = cmd_a;
                    m_in2  = cmd_b;
                    m_op   = cmd_opcode;
                end
                cyc++;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk);
        check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && mq.size() < DEPTH));
        check("busy",      32'(busy),      32'(m_busy));
        check("alu_input1", 32'(alu_input1), 32'(m_in1));
        check("alu_input2", 32'(alu_input2), 32'(m_in2));
        check("alu_opcode", 32'(alu_opcode), 32'(m_op));
        check("rsp_valid", 32'(rsp_valid), 32'(mq.size() > 0));
        check("err_count", 32'(err_count), 32'(m_errcnt));
        if (mq.size() > 0) begin
            check("rsp_result", rsp_result,       mq[0].res);
            check("rsp_error",  32'(rsp_error),   32'(mq[0].err));
            check("rsp_opcode", 32'(rsp_opcode),  32'(mq[0].op));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 0;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                @(negedge clk);
                done = 1;
                last_acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input logic [31:0] res, input logic [1:0] err,
                            input logic [3:0] op, input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (rsp_valid) begin
                got = 1;
                check({nm, " result"}, rsp_result, res);
                check({nm, " error"},  32'(rsp_error), 32'(err));
                check({nm, " opcode"}, 32'(rsp_opcode), 32'(op));
            end
            @(negedge clk);
        end
        if (!got) check({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  frc;
        logic [31:0] res;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'd2, 16'd5,      16'd9,   2'b00, 32'hFFFF_FFFC, 2'b01},
        '{4'd3, 16'd300,    16'd300, 2'b00, 32'd90000,     2'b00},
        '{4'd5, 16'd17,     16'd5,   2'b00, 32'd2,         2'b00},
        '{4'd1, 16'hFFFF,   16'd2,   2'b00, 32'h0001_0001, 2'b01},
        '{4'd9, 16'd44,     16'd55,  2'b11, 32'd0,         2'b00},
        '{4'd3, 16'd3,      16'd7,   2'b11, 32'd21,        2'b00},
        '{4'd4, 16'd100,    16'd7,   2'b00, 32'd14,        2'b00}
    };

    // ---------------- directed scenarios ----------------
    initial begin
        int busy_n;
        int prev_acc;
        bit seen;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset cmd_ready",  32'(cmd_ready), 32'd1);
        check("reset rsp_valid",  32'(rsp_valid), 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset rsp_error",  32'(rsp_error), 32'd0);
        check("reset rsp_opcode", 32'(rsp_opcode), 32'd0);
        check("reset busy",       32'(busy), 32'd0);
        check("reset err_count",  32'(err_count), 32'd0);
        check("reset alu",        {alu_input1, alu_input2[11:0], alu_opcode}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Add 3+1
        send(4'd1, 16'd3, 16'd1);
        check("add alu_opcode in wait", 32'(alu_opcode), 32'd1);
        busy_n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) busy_n++;
            if (rsp_valid) seen = 1; else @(negedge clk);
        end
        check("add rsp_valid", 32'(seen), 32'd1);
        check("add result", rsp_result, 32'd4);
        check("add error",  32'(rsp_error), 32'd0);
        check("add opcode", 32'(rsp_opcode), 32'd1);
        @(negedge clk);
        check("add alu_opcode after", 32'(alu_opcode), 32'd0);
        check("add busy cycles", 32'(busy_n), 32'd2);

        // Divide by zero, then masked bit1 on an add
        send(4'd4, 16'd7, 16'd0);
        wait_rsp(32'd0, 2'b10, 4'd4, "div0");
        check("div0 err_count", 32'(err_count), 32'd1);
        force_err = 2'b10;
        send(4'd1, 16'd7, 16'd0);
        wait_rsp(32'd7, 2'b00, 4'd1, "masked add");
        check("masked err_count", 32'(err_count), 32'd1);
        force_err = 2'b00;

        // Mixed opcode table
        foreach (vecs[i]) begin
            force_err = vecs[i].frc;
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(vecs[i].res, vecs[i].err, vecs[i].op, "vector");
        end
        force_err = 2'b00;
        check("table err_count", 32'(err_count), 32'd3);

        // Backpressure: four fill the FIFO, fifth stalls
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'd1, 16'd10, 16'(i));
        cmd_opcode = 4'd1; cmd_a = 16'd10; cmd_b = 16'd5; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("full cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        fork
            send(4'd1, 16'd10, 16'd5);
            begin
                rsp_ready = 1'b1;
                for (int i = 1; i <= 5; i++) wait_rsp(32'(10 + i), 2'b00, 4'd1, "backpressure");
            end
        join

        // Back-to-back with continuous draining
        repeat (2) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    prev_acc = last_acc;
                    send(4'd1, 16'd100, 16'(i));
                    if (i > 0) check("accept spacing", 32'(last_acc - prev_acc), 32'd3);
                end
            end
            begin
                for (int i = 0; i < 8; i++) wait_rsp(32'(100 + i), 2'b00, 4'd1, "stream");
            end
        join

        // Reset while a multiply is in flight
        send(4'd3, 16'd3, 16'd5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst busy",      32'(busy), 32'd0);
        check("midrst alu",       {alu_input1, alu_input2}, 32'd0);
        check("midrst alu_opcode", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("midrst no response", 32'(seen), 32'd0);
        check("midrst err_count", 32'(err_count), 32'd0);

        // Saturating error counter
        for (int i = 0; i < 260; i++) begin
            send(4'd4, 16'(i), 16'd0);
            wait_rsp(32'd0, 2'b10, 4'd4, "sat");
            if (i == 254) check("sat reach 255", 32'(err_count), 32'd255);
        end
        check("sat hold 255", 32'(err_count), 32'd255);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_command_sequencer.md
# alu_command_sequencer

Sequential front-end that issues operations to the combinational 16-bit calculator datapath and collects its results. Commands (opcode plus two 16-bit operands) arrive on a valid/ready port. The block drives them onto the calculator's `input1`/`input2`/`opcode` pins and holds them for a fixed settle window. It then captures `result`/`error` with per-opcode error masking into a small in-order response FIFO, which drains on a valid/ready port.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the operands are held on the calculator before capture; legal range 1..15.
- `RSP_DEPTH`, default 4: response FIFO entries; power of two, minimum 2.

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command can be accepted
- `cmd_opcode`  in  4  0 ground, 1 add, 2 sub, 3 mul, 4 div, 5 mod, 6..15 ground
- `cmd_a`  in  16  operand A
- `cmd_b`  in  16  operand B
- `alu_input1`  out  16  to calculator `input1`
- `alu_input2`  out  16  to calculator `input2`
- `alu_opcode`  out  4  to calculator `opcode`
- `alu_result`  in  32  from calculator `result`
- `alu_error`  in  2  from calculator `error`; bit1 is divide/mod-by-zero, bit0 is overflow
- `rsp_valid`  out  1  FIFO head valid
- `rsp_ready`  in  1  consumer pops head
- `rsp_result`  out  32  head result
- `rsp_error`  out  2  head masked error
- `rsp_opcode`  out  4  head opcode
- `busy`  out  1  command in flight
- `err_count`  out  8  saturating count of responses with a nonzero masked error

## Operation
- FSM has two states:
  - IDLE: `cmd_ready = (state==IDLE) && (fifo_count < RSP_DEPTH)`, combinational.
  - WAIT: entered on a command handshake (`cmd_valid && cmd_ready`) at a clock edge.
- At accept:
  - Register `cmd_a`, `cmd_b` and `cmd_opcode` onto the `alu_*` outputs.
  - Load the settle counter with `SETTLE_CYCLES`.
  - Go to WAIT.
- WAIT:
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, push `{alu_opcode, masked error, alu_result}` into the FIFO.
  - On that same edge, drive `alu_opcode` to 0 (ground channel) and return to IDLE.
  - `alu_input1`/`alu_input2` keep their last values.
- Error masking:
  - `rsp_error[1] = alu_error[1]` only for opcode 4 or 5, else 0.
  - `rsp_error[0] = alu_error[0]` only for opcode 1 or 2, else 0.
- Ground opcodes (0, 6..15) are accepted and issued normally; their response carries the calculator output unmodified (expected 0) and error 00.
- `err_count` increments on each push whose masked error is nonzero, and saturates at 255.
- FIFO:
  - Order is strictly preserved.
  - A pop occurs on `rsp_valid && rsp_ready`.
  - A push and a pop on the same edge leave the count unchanged.
  - Overflow cannot occur: accept requires a free slot, and only one command is in flight.
  - Pointers wrap modulo `RSP_DEPTH`.
- `busy = (state==WAIT)`.

## Timing
- Reset values:
  - State IDLE; FIFO empty, pointers 0.
  - `alu_input1`, `alu_input2`, `alu_opcode` = 0.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_error` = 0, `rsp_opcode` = 0.
  - `err_count` = 0, `busy` = 0.
  - `cmd_ready` = 1, combinational from the reset state.
- Latency: accept at edge E. The `alu_*` ports are valid after E. Capture happens at edge E+SETTLE_CYCLES. `rsp_valid` rises after that edge if the FIFO was empty.
- `cmd_ready` is low from after E until after the capture edge. The next accept is possible at E+SETTLE_CYCLES+1, so throughput is one command per SETTLE_CYCLES+1 cycles.
- With the FIFO full, `cmd_ready` stays low. It rises in the cycle after the first pop edge.
- Reset asserted mid-WAIT: the in-flight command and all FIFO contents are discarded immediately. No response is produced for them.
- The `rsp_*` head outputs are stable while `rsp_valid && !rsp_ready`.

## Test plan
- Add: reset, then `cmd_opcode`=1, a=3, b=1, `rsp_ready`=1, accept at edge E.
  - Expect `alu_opcode`=1 during WAIT.
  - Expect `rsp_valid` after E+2 with `rsp_result`=4, `rsp_error`=00, `rsp_opcode`=1.
  - Expect `alu_opcode`=0 afterwards and `busy` high for exactly 2 cycles.
- Divide by zero: opcode 4, a=7, b=0.
  - Expect `rsp_error`=10 and `err_count`=1.
  - Then opcode 1, a=7, b=0 with the calculator still flagging bit1: expect `rsp_error`=00 and `err_count` unchanged at 1.
- Backpressure: `rsp_ready`=0, offer 5 commands (add with b=1..5, a=10).
  - Expect exactly 4 accepts, then `cmd_ready`=0 held.
  - Set `rsp_ready`=1: expect results 11, 12, 13, 14 in order, and the 5th command accepted after the first pop, returning 15.
- Simultaneous push and pop: `rsp_ready`=1 continuously, 8 back-to-back commands.
  - Expect the FIFO count never to exceed 1.
  - Expect the accept spacing to be exactly SETTLE_CYCLES+1 cycles.
- Reset mid-operation: assert `rst` one cycle after accepting mul a=3, b=5.
  - Expect `rsp_valid`=0, `alu_*`=0, `busy`=0 immediately, and no response after release.
- Saturation: 260 consecutive div-by-zero commands.
  - Expect `err_count` to reach 255 and hold there.
  - Expect every `rsp_error` to be 10.
